// File: rtl/trace_cmd_sequencer.sv
// Trace command sequencer: accepts parser commands, issues one cache request
// at a time, handles clear/print/illegal opcodes and keeps hit/miss stats.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      parser handshake; cmd_opcode, cmd_addr payload
//   cache_req/cache_ack      cache request handshake; cache_hit valid with ack
//   cache_op/tag/index       latched request fields, stable while cache_req=1
//   rd/wr/hit/miss_cnt       saturating statistics counters
//   dump_pulse, bad_op       one-cycle strobes for print and illegal opcodes
module trace_cmd_sequencer #(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 14,
  parameter int OFFSET_W = 6,
  parameter int CNT_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [3:0]                      cmd_opcode,
  input  logic [ADDR_W-1:0]               cmd_addr,
  output logic                            cache_req,
  output logic [2:0]                      cache_op,
  output logic [ADDR_W-INDEX_W-OFFSET_W-1:0] cache_tag,
  output logic [INDEX_W-1:0]              cache_index,
  input  logic                            cache_ack,
  input  logic                            cache_hit,
  output logic [CNT_W-1:0]                rd_cnt,
  output logic [CNT_W-1:0]                wr_cnt,
  output logic [CNT_W-1:0]                hit_cnt,
  output logic [CNT_W-1:0]                miss_cnt,
  output logic                            dump_pulse,
  output logic                            bad_op
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_PRINT,
    S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [CNT_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]   wr_q, wr_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   miss_q, miss_d;

  // Byte-offset bits select within a line and carry no meaning here.
  logic unused_offset;
  assign unused_offset = ^cmd_addr[OFFSET_W-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tag_d   = tag_q;
    index_d = index_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          tag_d   = cmd_addr[ADDR_W-1:INDEX_W+OFFSET_W];
          index_d = cmd_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
          case (cmd_opcode)
            4'd0, 4'd1, 4'd2, 4'd3,
            4'd4, 4'd5, 4'd6: begin
              op_d    = cmd_opcode[2:0];
              state_d = S_REQ;
            end
            4'd8: begin
              op_d    = 3'd7;
              state_d = S_REQ;
            end
            4'd9:    state_d = S_PRINT;
            default: state_d = S_ERR;
          endcase
        end
      end
      S_REQ: begin
        if (cache_ack) begin
          state_d = S_IDLE;
          case (op_q)
            3'd0, 3'd1, 3'd2: begin
              if (op_q == 3'd1) wr_d = sat_inc(wr_q);
              else              rd_d = sat_inc(rd_q);
              if (cache_hit) hit_d  = sat_inc(hit_q);
              else           miss_d = sat_inc(miss_q);
            end
            3'd7: begin
              rd_d   = '0;
              wr_d   = '0;
              hit_d  = '0;
              miss_d = '0;
            end
            default: ;
          endcase
        end
      end
      S_PRINT: state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tag_q   <= '0;
      index_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign cache_req   = (state_q == S_REQ);
  assign dump_pulse  = (state_q == S_PRINT);
  assign bad_op      = (state_q == S_ERR);
  assign cache_op    = op_q;
  assign cache_tag   = tag_q;
  assign cache_index = index_q;
  assign rd_cnt      = rd_q;
  assign wr_cnt      = wr_q;
  assign hit_cnt     = hit_q;
  assign miss_cnt    = miss_q;

endmodule
